// File: rtl/chip_word_serializer.sv
// chip_word_serializer: shifts a captured word MSB-first with serial clock and latch strobe; define CHIP_SER_PARITY_EN to append an odd-parity bit
module chip_word_serializer #(
    parameter int bit_chip = 6,
    parameter int half_div = 2
) (
    input  logic                clk_main,
    input  logic                rst,
    input  logic                load,
    input  logic [bit_chip-1:0] data_in,
    output logic                busy,
    output logic                done,
    output logic                overrun,
    output logic                sclk_out,
    output logic                sdata_out,
    output logic                latch_out
);
`ifdef CHIP_SER_PARITY_EN
    localparam int N = bit_chip + 1;
    logic [N-1:0] cap;
    assign cap = {data_in, ~^data_in};
`else
    localparam int N = bit_chip;
    logic [N-1:0] cap;
    assign cap = data_in;
`endif
    localparam int BW = $clog2(N + 1);
    localparam int HW = half_div > 1 ? $clog2(half_div) : 1;
    typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;
    state_t state;
    logic [N-1:0] sr;
    logic [BW-1:0] bcnt;
    logic [HW-1:0] hcnt;
    logic half_end, last_bit;
    assign half_end = hcnt == HW'(half_div - 1);
    assign last_bit = bcnt == BW'(N - 1);
    // sr empties to zero after N shifts, so its MSB doubles as the registered data line
    assign sdata_out = sr[N-1];
    always_ff @(posedge clk_main) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            bcnt      <= '0;
            hcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            sclk_out  <= 1'b0;
            latch_out <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (load) begin
                    sr    <= cap;
                    bcnt  <= '0;
                    hcnt  <= '0;
                    busy  <= 1'b1;
                    state <= LOW;
                end
                LOW: begin
                    hcnt <= half_end ? '0 : hcnt + 1'b1;
                    if (half_end) begin
                        sclk_out <= 1'b1;
                        state    <= HIGH;
                    end
                end
                HIGH: begin
                    hcnt <= half_end ? '0 : hcnt + 1'b1;
                    if (half_end) begin
                        sclk_out  <= 1'b0;
                        bcnt      <= bcnt + 1'b1;
                        sr        <= sr << 1;
                        latch_out <= last_bit;
                        state     <= last_bit ? LATCH : LOW;
                    end
                end
                LATCH: begin
                    hcnt <= half_end ? '0 : hcnt + 1'b1;
                    if (half_end) begin
                        latch_out <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/chip_word_serializer.md
# chip_word_serializer

Downstream stage of the landscape-sampling probability block. It takes the `bit_chip`-wide word read from the probability RAM (`bit_to_chip`) and shifts it serially, MSB first, into the chip's bias shift register. It generates the serial clock, data and latch strobe, and reports completion with a `done` pulse. It runs in the `clk_main` domain with a capture/busy handshake toward the sampling controller.

## Interface
Parameters:
- `bit_chip`, 6: width of the parallel word; number of data bits shifted.
- `half_div`, 2: `clk_main` cycles per serial-clock half period; legal range is ≥1.

Ports:
- `clk_main`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load`  in  1  single-cycle request to capture `data_in` and start a transfer.
- `data_in`  in  `bit_chip`  word to send (the `bit_to_chip` output).
- `busy`  out  1  high while a transfer is in progress.
- `done`  out  1  one-cycle pulse when a transfer finishes.
- `overrun`  out  1  sticky flag: a `load` arrived while `busy`; cleared only by `rst`.
- `sclk_out`  out  1  serial clock to the chip; idles low.
- `sdata_out`  out  1  serial data to the chip.
- `latch_out`  out  1  latch strobe to the chip.

The design has one clock; reset is synchronous and active-high.

## Operation
- **Reset values:** every output is 0, state is IDLE, and all counters are 0.
- **Registers:**
  - shift register `sr`, width N;
  - bit counter, `$clog2(N+1)` bits;
  - half-period counter, `$clog2(half_div)` bits (minimum 1).
- **N** equals `bit_chip`, or `bit_chip+1` when parity is enabled (see Configuration).
- **State machine** with states IDLE, LOW, HIGH, LATCH:
  - **IDLE:** `busy`=0. When `load`=1, capture `data_in` into `sr` (parity appended as LSB if enabled), drive `sdata_out` with the MSB, clear the counters, and go to LOW.
  - **LOW:** `sclk_out`=0 for `half_div` cycles, then go to HIGH.
  - **HIGH:** `sclk_out`=1 for `half_div` cycles. On exit, increment the bit counter and shift `sr` left by one.
    - If the counter reaches N, go to LATCH with `sdata_out`=0.
    - Otherwise go to LOW with `sdata_out` set to the new MSB.
  - **LATCH:** `latch_out`=1 and `sclk_out`=0 for `half_div` cycles. Then go to IDLE and assert `done` for exactly one cycle (the first IDLE cycle).
- **Data stability:** `sdata_out` changes only on LOW entry. It is therefore stable for the whole HIGH phase, including the rising edge of `sclk_out`.
- **`load` while busy** (LOW, HIGH or LATCH): the load is ignored, the captured word is unaffected, and `overrun` is set to 1 from the next cycle.
- **`load` during the `done` cycle:** the state is IDLE, so the load is accepted normally with no overrun.
- **`data_in` handling:** `data_in` is sampled only in the `load` cycle. Later changes have no effect.
- **`rst` mid-transfer:** the transfer aborts. All outputs return to 0 on the next edge, no `done` is issued, and the chip latch is not strobed.

## Timing
- **Start latency:** with `load` at cycle t, `busy`=1 and `sdata_out`=MSB at t+1.
- **Serial clock:**
  - first `sclk_out` rise at t+1+`half_div`;
  - rising edge k (k=0..N-1) at t+1+`half_div`·(2k+1).
- **Latch:** `latch_out` is high over cycles t+1+2·`half_div`·N through t+`half_div`·(2N+1).
- **Busy duration:** `busy` lasts `half_div`·(2N+1) cycles. `done`=1 and `busy`=0 at cycle t+1+`half_div`·(2N+1).
- **Back-to-back throughput:** one word per `half_div`·(2N+1)+1 cycles.
- **Output registers:** all outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`CHIP_SER_PARITY_EN` defined:** an odd-parity bit is appended after the data LSB, giving N=`bit_chip`+1. The parity bit is the value that makes the total number of 1s across the data plus parity odd, i.e. `~^data_in`.
- **Not defined:** N=`bit_chip` and no parity logic is present.

## Test plan
Default parameters (`bit_chip`=6, `half_div`=2) unless stated.
1. **Reset:** hold `rst` 3 cycles, then release → all outputs 0, `busy` stays 0 with no `load`.
2. **Basic transfer, parity off:** `load` with `data_in`=6'b101101 at cycle 10 →
   - `sdata_out` sampled at `sclk_out` rises gives 1,0,1,1,0,1;
   - rises at cycles 13,17,21,25,29,33;
   - `latch_out` high at cycles 35–36;
   - `done` at cycle 37;
   - `busy` high for 26 cycles.
3. **Parity on** (`CHIP_SER_PARITY_EN`): `data_in`=6'b101101 → 7 bits shifted, 1,0,1,1,0,1,1; `busy` high for 30 cycles. With `data_in`=6'b000111 the parity bit is 0.
4. **Overrun:** second `load` at the 5th busy cycle with a different word → original word shifted unchanged, `overrun`=1 from the following cycle and still 1 after `done`.
5. **Back-to-back:** `load` asserted in the `done` cycle with 6'b010010 → accepted, `overrun` stays 0, second transfer starts the next cycle.
6. **Reset mid-shift:** `rst` during the 3rd bit → outputs 0 on the next edge, `latch_out` never asserted, no `done`; a subsequent `load` completes normally.
